onc_16_mem_resp: RTL and testbench

- Memory-side responder for the ONC-16 core. It serves the core's instruction-fetch and data-memory requests through the imem_*/dmem_* interface and drives the core's `en` input.
- It contains the instruction and data memory arrays and a host program-loader FSM.
- The loader writes the program into instruction memory, then releases the core.
- It sits beside onc_16_pl at the top level.

---
 rtl/onc_16_mem_resp_pkg.sv | 16 +
 rtl/onc_16_mem_sp.sv | 38 +++
 rtl/onc_16_mem_resp.sv | 120 ++++++++++++
 tb/tb_onc_16_mem_resp.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onc_16_mem_resp_pkg.sv
// Shared definitions for the ONC-16 memory responder: data/instruction
// widths, loader FSM state encoding and the MMIO address.
package onc_16_mem_resp_pkg;

  localparam int unsigned ONC16_DATA_W = 16;
  localparam int unsigned ONC16_INST_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [ONC16_DATA_W-1:0] MMIO_ADDR = 16'hFFFF;

endpackage

// File: rtl/onc_16_mem_sp.sv
// Simple memory array: asynchronous read, synchronous write.
// Addresses are masked to the low AW bits, so upper bits alias.
module onc_16_mem_sp #(
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;

  assign wa = waddr[AW-1:0];
  assign ra = raddr[AW-1:0];

  // Synchronous write; contents are never reset
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wa] <= wdata;
    end
  end

  // Zero-latency read; a same-cycle write is only visible next cycle
  assign rdata = mem[ra];

  if (ADDR_W > AW) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^{waddr[ADDR_W-1:AW], raddr[ADDR_W-1:AW]};
  end

endmodule

// File: rtl/onc_16_mem_resp.sv
// ONC-16 memory-side responder: instruction and data memories, host
// program loader FSM (IDLE/LOAD/RUN) and the core enable.
// Optional MMIO register at 16'hFFFF enabled by defining ONC16_MMIO_EN.
module onc_16_mem_resp
  import onc_16_mem_resp_pkg::*;
#(
  parameter int unsigned DATA_W  = ONC16_DATA_W,
  parameter int unsigned IMEM_AW = 8,
  parameter int unsigned DMEM_AW = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_din,
  input  logic [DATA_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_dout,
  input  logic              dmem_we,
  output logic [DATA_W-1:0] dmem_din,
  output logic              cpu_en,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_err,
  output logic [DATA_W-1:0] io_out,
  input  logic [DATA_W-1:0] io_in
);

  localparam logic [IMEM_AW:0] PTR_ONE  = 1;
  localparam logic [IMEM_AW:0] PTR_LAST = {1'b0, {IMEM_AW{1'b1}}};

  state_t            state;
  logic [IMEM_AW:0]  ptr;
  logic              accept;
  logic [DATA_W-1:0] imem_waddr;
  logic              dmem_wr_ok;
  logic              dmem_wr;
  logic [DATA_W-1:0] dmem_rdata;

  assign ld_ready   = (state == ST_LOAD);
  // ld_start has priority over a word offered in the same cycle
  assign accept     = ld_valid && ld_ready && !ld_start;
  assign imem_waddr = DATA_W'(ptr);
  assign dmem_wr_ok = (state == ST_RUN) && (dmem_we === 1'b1);

  // Loader FSM, load pointer, sticky overflow flag and core enable
  always_ff @(posedge clock) begin
    if (rst) begin
      state  <= ST_IDLE;
      cpu_en <= 1'b0;
      ld_err <= 1'b0;
      ptr    <= '0;
    end else begin
      cpu_en <= (state == ST_RUN);
      if (ld_start) begin
        state  <= ST_LOAD;
        ptr    <= '0;
        ld_err <= 1'b0;
      end else if (accept) begin
        ptr <= ptr + PTR_ONE;
        if (ld_last) begin
          state <= ST_RUN;
        end else if (ptr == PTR_LAST) begin
          ld_err <= 1'b1;
          state  <= ST_RUN;
        end
      end
    end
  end

  onc_16_mem_sp #(
    .DW     (DATA_W),
    .AW     (IMEM_AW),
    .ADDR_W (DATA_W)
  ) u_imem (
    .clock (clock),
    .we    (accept),
    .waddr (imem_waddr),
    .wdata (ld_data),
    .raddr (imem_addr),
    .rdata (imem_din)
  );

  onc_16_mem_sp #(
    .DW     (DATA_W),
    .AW     (DMEM_AW),
    .ADDR_W (DATA_W)
  ) u_dmem (
    .clock (clock),
    .we    (dmem_wr),
    .waddr (dmem_addr),
    .wdata (dmem_dout),
    .raddr (dmem_addr),
    .rdata (dmem_rdata)
  );

`ifdef ONC16_MMIO_EN
  logic mmio_hit;
  assign mmio_hit = (dmem_addr == DATA_W'(MMIO_ADDR));
  assign dmem_wr  = dmem_wr_ok && !mmio_hit;
  assign dmem_din = mmio_hit ? io_in : dmem_rdata;

  // MMIO output register, captured on RUN-state stores to MMIO_ADDR
  always_ff @(posedge clock) begin
    if (rst) begin
      io_out <= '0;
    end else if (dmem_wr_ok && mmio_hit) begin
      io_out <= dmem_dout;
    end
  end
`else
  logic unused_io;
  assign unused_io = ^io_in;
  assign dmem_wr   = dmem_wr_ok;
  assign dmem_din  = dmem_rdata;
  assign io_out    = '0;
`endif

endmodule

// File: tb/tb_onc_16_mem_resp.sv
// Self-checking bench for onc_16_mem_resp (default 8-bit IMEM plus a
// 2-bit IMEM instance for overflow), against a memory/array model.
module tb_onc_16_mem_resp;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // main instance signals
  logic        rst, dmem_we, cpu_en, ld_start, ld_valid, ld_ready, ld_last, ld_err;
  logic [15:0] imem_addr, imem_din, dmem_addr, dmem_dout, dmem_din, ld_data, io_out, io_in;
  // small instance signals
  logic        s_rst, s_dmem_we, s_cpu_en, s_ld_start, s_ld_valid, s_ld_ready, s_ld_last, s_ld_err;
  logic [15:0] s_imem_addr, s_imem_din, s_dmem_addr, s_dmem_dout, s_dmem_din, s_ld_data, s_io_out, s_io_in;

  // reference memories
  logic [15:0] im_m [256];
  bit          im_k [256];
  logic [15:0] dm_m [256];
  bit          dm_k [256];
  logic [15:0] s_im [4];

  onc_16_mem_resp dut (
    .clock(clock), .rst(rst), .imem_addr(imem_addr), .imem_din(imem_din),
    .dmem_addr(dmem_addr), .dmem_dout(dmem_dout), .dmem_we(dmem_we), .dmem_din(dmem_din),
    .cpu_en(cpu_en), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .ld_err(ld_err), .io_out(io_out), .io_in(io_in)
  );

  onc_16_mem_resp #(.DATA_W(16), .IMEM_AW(2), .DMEM_AW(8)) dut_s (
    .clock(clock), .rst(s_rst), .imem_addr(s_imem_addr), .imem_din(s_imem_din),
    .dmem_addr(s_dmem_addr), .dmem_dout(s_dmem_dout), .dmem_we(s_dmem_we), .dmem_din(s_dmem_din),
    .cpu_en(s_cpu_en), .ld_start(s_ld_start), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready),
    .ld_data(s_ld_data), .ld_last(s_ld_last), .ld_err(s_ld_err), .io_out(s_io_out), .io_in(s_io_in)
  );

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    rst = 1'b1; s_rst = 1'b1;
    tick(); tick();
    rst = 1'b0; s_rst = 1'b0;
    n_cmp++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    n_cmp++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL reset_ld_err: got %b want 0", ld_err); end
    n_cmp++; if (io_out !== 16'h0) begin n_fail++; $display("FAIL reset_io_out: got %h want 0000", io_out); end
    n_cmp++; if (s_ld_ready !== 1'b0 || s_cpu_en !== 1'b0 || s_ld_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_small: got rdy=%b en=%b err=%b want 0/0/0", s_ld_ready, s_cpu_en, s_ld_err);
    end
    tick();
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ld_ready: got %b want 0", ld_ready); end
  endtask

  task automatic test_load_basic();
    logic [15:0] w [3];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = w[i]; ld_last = (i == 2);
      n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready[%0d]: got %b want 1", i, ld_ready); end
      tick();
      im_m[i] = w[i]; im_k[i] = 1'b1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_cmp++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL basic_en_early: got %b want 0", cpu_en); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_after: got %b want 0", ld_ready); end
    tick();
    n_cmp++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL basic_en: got %b want 1", cpu_en); end
    for (int i = 0; i < 3; i++) begin
      imem_addr = 16'(i);
      #1;
      n_cmp++; if (imem_din !== w[i]) begin n_fail++; $display("FAIL basic_imem[%0d]: got %h want %h", i, imem_din, w[i]); end
    end
    imem_addr = 16'hAB02;
    #1;
    n_cmp++; if (imem_din !== 16'h3333) begin n_fail++; $display("FAIL basic_imem_alias: got %h want 3333", imem_din); end
  endtask

  task automatic test_dmem_rw();
    logic [15:0] a, d;
    bit          we;
    dmem_addr = 16'h0005; dmem_dout = 16'h1234; dmem_we = 1'b1;
    tick();
    dmem_dout = 16'hABCD;
    #1;
    n_cmp++; if (dmem_din !== 16'h1234) begin n_fail++; $display("FAIL dmem_old_on_write: got %h want 1234", dmem_din); end
    tick();
    dmem_we = 1'b0;
    #1;
    n_cmp++; if (dmem_din !== 16'hABCD) begin n_fail++; $display("FAIL dmem_new: got %h want abcd", dmem_din); end
    dmem_addr = 16'h0105;
    #1;
    n_cmp++; if (dmem_din !== 16'hABCD) begin n_fail++; $display("FAIL dmem_alias: got %h want abcd", dmem_din); end
    dm_m[5] = 16'hABCD; dm_k[5] = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a = 16'($urandom);
      if (a == 16'hFFFF) a = 16'h00FF;
      d = 16'($urandom);
      we = bit'($urandom_range(0, 1));
      dmem_addr = a; dmem_dout = d; dmem_we = we;
      imem_addr = {8'($urandom), 8'($urandom_range(0, 2))};
      #1;
      if (dm_k[a[7:0]]) begin
        n_cmp++; if (dmem_din !== dm_m[a[7:0]]) begin n_fail++; $display("FAIL dmem_rand[%0d]: addr %h got %h want %h", i, a, dmem_din, dm_m[a[7:0]]); end
      end
      n_cmp++; if (imem_din !== im_m[imem_addr[7:0]]) begin n_fail++; $display("FAIL imem_rand[%0d]: addr %h got %h want %h", i, imem_addr, imem_din, im_m[imem_addr[7:0]]); end
      tick();
      if (we) begin dm_m[a[7:0]] = d; dm_k[a[7:0]] = 1'b1; end
    end
    dmem_we = 1'b0;
  endtask

  task automatic test_we_guard_run();
    dmem_addr = 16'h0003; dmem_dout = 16'h3333; dmem_we = 1'b1;
    tick();
    dm_m[3] = 16'h3333; dm_k[3] = 1'b1;
    dmem_dout = 16'hDEAD; dmem_we = 1'bx;
    tick();
    dmem_we = 1'b0;
    #1;
    n_cmp++; if (dmem_din !== 16'h3333) begin n_fail++; $display("FAIL we_x_ignored: got %h want 3333", dmem_din); end
  endtask

  task automatic test_random_load();
    int unsigned n;
    logic [15:0] wd;
    n = $urandom_range(8, 30);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rl_ready_start: got %b want 1", ld_ready); end
    // store attempted while loading must be dropped
    dmem_addr = 16'h0003; dmem_dout = 16'hBEEF; dmem_we = 1'b1;
    tick();
    dmem_we = 1'b0;
    n_cmp++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL abort_en_drop: got %b want 0", cpu_en); end
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned g = $urandom_range(0, 2); g > 0; g--) begin
        ld_valid = 1'b0;
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rl_ready_gap[%0d]: got %b want 1", i, ld_ready); end
        tick();
      end
      wd = 16'($urandom);
      ld_valid = 1'b1; ld_data = wd; ld_last = (i == n - 1);
      n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rl_ready[%0d]: got %b want 1", i, ld_ready); end
      tick();
      im_m[i] = wd; im_k[i] = 1'b1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_cmp++; if (cpu_en !== 1'b0 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL rl_after_last: got en=%b rdy=%b want 0/0", cpu_en, ld_ready); end
    tick();
    n_cmp++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL rl_en: got %b want 1", cpu_en); end
    n_cmp++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL rl_err: got %b want 0", ld_err); end
    dmem_addr = 16'h0003;
    #1;
    n_cmp++; if (dmem_din !== dm_m[3]) begin n_fail++; $display("FAIL load_no_dmem_write: got %h want %h", dmem_din, dm_m[3]); end
    for (int unsigned i = 0; i < n; i++) begin
      imem_addr = {8'($urandom), 8'(i)};
      #1;
      n_cmp++; if (imem_din !== im_m[i]) begin n_fail++; $display("FAIL rl_imem[%0d]: got %h want %h", i, imem_din, im_m[i]); end
    end
  endtask

  task automatic test_start_vs_valid();
    logic [15:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = w[i]; ld_last = 1'b0;
      tick();
      im_m[i] = w[i];
    end
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 16'hEEEE;
    tick();
    ld_start = 1'b0; ld_data = 16'hF00D; ld_last = 1'b1;
    tick();
    im_m[0] = 16'hF00D;
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    n_cmp++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL sv_en: got %b want 1", cpu_en); end
    for (int i = 0; i < 5; i++) begin
      imem_addr = 16'(i);
      #1;
      n_cmp++; if (imem_din !== im_m[i]) begin n_fail++; $display("FAIL start_wins[%0d]: got %h want %h", i, imem_din, im_m[i]); end
    end
  endtask

  task automatic test_mmio();
    dmem_addr = 16'h00FF; dmem_dout = 16'h1111; dmem_we = 1'b1;
    tick();
    dm_m[255] = 16'h1111;
    dmem_addr = 16'hFFFF; dmem_dout = 16'h00C3;
    tick();
    dmem_we = 1'b0;
    io_in = 16'h5A5A;
`ifdef ONC16_MMIO_EN
    n_cmp++; if (io_out !== 16'h00C3) begin n_fail++; $display("FAIL mmio_io_out: got %h want 00c3", io_out); end
    #1;
    n_cmp++; if (dmem_din !== 16'h5A5A) begin n_fail++; $display("FAIL mmio_read: got %h want 5a5a", dmem_din); end
`else
    dm_m[255] = 16'h00C3;
    n_cmp++; if (io_out !== 16'h0000) begin n_fail++; $display("FAIL io_out_tied: got %h want 0000", io_out); end
    #1;
    n_cmp++; if (dmem_din !== 16'h00C3) begin n_fail++; $display("FAIL ffff_alias_read: got %h want 00c3", dmem_din); end
`endif
    dmem_addr = 16'h00FF;
    #1;
    n_cmp++; if (dmem_din !== dm_m[255]) begin n_fail++; $display("FAIL dmem_255: got %h want %h", dmem_din, dm_m[255]); end
  endtask

  task automatic test_idle_guard();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (cpu_en !== 1'b0 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL rerst: got en=%b rdy=%b want 0/0", cpu_en, ld_ready); end
    dmem_addr = 16'h0003; dmem_dout = 16'h7777; dmem_we = 1'b1;
    tick();
    dmem_we = 1'b0;
    #1;
    n_cmp++; if (dmem_din !== dm_m[3]) begin n_fail++; $display("FAIL idle_write_ignored: got %h want %h", dmem_din, dm_m[3]); end
    imem_addr = 16'h0001;
    #1;
    n_cmp++; if (imem_din !== im_m[1]) begin n_fail++; $display("FAIL imem_kept_over_reset: got %h want %h", imem_din, im_m[1]); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) s_im[i % 4] = (i < 4) ? 16'($urandom) : s_im[i % 4];
    s_ld_start = 1'b1;
    tick();
    s_ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_ld_valid = 1'b1; s_ld_last = 1'b0;
      s_ld_data = (i < 4) ? s_im[i] : 16'hBAD5;
      n_cmp++; if (s_ld_ready !== (i < 4)) begin n_fail++; $display("FAIL ovf_ready[%0d]: got %b want %b", i, s_ld_ready, (i < 4)); end
      if (i == 4) begin
        n_cmp++; if (s_ld_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", s_ld_err); end
      end
      tick();
    end
    s_ld_valid = 1'b0;
    n_cmp++; if (s_cpu_en !== 1'b1) begin n_fail++; $display("FAIL ovf_run: got %b want 1", s_cpu_en); end
    for (int i = 0; i < 4; i++) begin
      s_imem_addr = 16'(i + 4);
      #1;
      n_cmp++; if (s_imem_din !== s_im[i]) begin n_fail++; $display("FAIL ovf_imem[%0d]: got %h want %h", i, s_imem_din, s_im[i]); end
    end
  endtask

  task automatic test_abort_small();
    s_ld_start = 1'b1;
    tick();
    s_ld_start = 1'b0;
    n_cmp++; if (s_ld_err !== 1'b0) begin n_fail++; $display("FAIL abort_err_clr: got %b want 0", s_ld_err); end
    n_cmp++; if (s_ld_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", s_ld_ready); end
    s_ld_valid = 1'b1; s_ld_data = 16'h9999; s_ld_last = 1'b1;
    tick();
    s_ld_valid = 1'b0; s_ld_last = 1'b0;
    s_im[0] = 16'h9999;
    n_cmp++; if (s_cpu_en !== 1'b0) begin n_fail++; $display("FAIL abort_en_small: got %b want 0", s_cpu_en); end
    for (int i = 0; i < 2; i++) begin
      s_imem_addr = 16'(i);
      #1;
      n_cmp++; if (s_imem_din !== s_im[i]) begin n_fail++; $display("FAIL abort_imem[%0d]: got %h want %h", i, s_imem_din, s_im[i]); end
    end
  endtask

  initial begin
    rst = 1'b0; dmem_we = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    imem_addr = '0; dmem_addr = '0; dmem_dout = '0; ld_data = '0; io_in = '0;
    s_rst = 1'b0; s_dmem_we = 1'b0; s_ld_start = 1'b0; s_ld_valid = 1'b0; s_ld_last = 1'b0;
    s_imem_addr = '0; s_dmem_addr = '0; s_dmem_dout = '0; s_ld_data = '0; s_io_in = '0;
    for (int i = 0; i < 256; i++) begin im_m[i] = '0; im_k[i] = 1'b0; dm_m[i] = '0; dm_k[i] = 1'b0; end
    test_reset();
    test_load_basic();
    test_dmem_rw();
    test_we_guard_run();
    test_random_load();
    test_start_vs_valid();
    test_mmio();
    test_idle_guard();
    test_overflow();
    test_abort_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
